// File: rtl/reg_pkg.sv
// Shared types and constants for the register-file write controller.
package reg_pkg;

  localparam logic [3:0] REG_PC   = 4'd8;
  localparam logic [3:0] REG_SP   = 4'd9;
  localparam logic [3:0] REG_FLAG = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        wide;
  } wb_req_t;

  // A request is split into two half-word writes only when it is flagged
  // wide and targets one of the two 32-bit registers.
  function automatic logic is_split(input wb_req_t req,
                                    input logic [3:0] pc_addr,
                                    input logic [3:0] sp_addr);
    return req.wide && ((req.addr == pc_addr) || (req.addr == sp_addr));
  endfunction

endpackage

// File: rtl/reg_write_ctrl_wb_fifo.sv
// Request FIFO for writeback requests, with a per-entry address view used
// by the hazard check.
module wb_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_req,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][3:0]        entry_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Storage array; contents need no reset because validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_req;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [AW-1:0] offset;
    assign offset          = AW'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    assign entry_addr[gi]  = mem[gi].addr;
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Writeback-to-register-file write master: queues requests, splits 32-bit
// PC/SP writes into two half-word writes and reports pending-write hits.
module reg_write_ctrl
  import reg_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         DW      = 16,
  parameter logic [3:0] PC_ADDR = REG_PC,
  parameter logic [3:0] SP_ADDR = REG_SP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [3:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          wb_wide,
  output logic          wb_ready,
  output logic          write_enable,
  output logic [3:0]    write_addr,
  output logic [DW-1:0] write_data,
  output logic          dirc_byte,
  input  logic [3:0]    chk_addr,
  output logic          chk_hit,
  output logic          idle
);

  wr_state_t                 state_reg;
  wr_state_t                 state_next;
  logic [3:0]                held_addr_reg;
  logic [15:0]               held_hi_reg;

  wb_req_t                   push_req;
  wb_req_t                   head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic [DEPTH-1:0]          entry_valid;
  logic [DEPTH-1:0][3:0]     entry_addr;
  logic [DEPTH-1:0]          fifo_hit;

  logic                      pop;
  logic                      load_held;
  logic                      write_enable_next;
  logic [3:0]                write_addr_next;
  logic [DW-1:0]             write_data_next;
  logic                      dirc_byte_next;

  assign push_req = '{addr: wb_addr, data: wb_data, wide: wb_wide};
  assign wb_ready = !fifo_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (wb_valid),
    .push_req    (push_req),
    .pop         (pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // State, held wide entry and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      held_addr_reg <= '0;
      held_hi_reg   <= '0;
      write_enable  <= 1'b1;
      write_addr    <= '0;
      write_data    <= '0;
      dirc_byte     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_held) begin
        held_addr_reg <= head.addr;
        held_hi_reg   <= head.data[31:16];
      end
      write_enable <= write_enable_next;
      write_addr   <= write_addr_next;
      write_data   <= write_data_next;
      dirc_byte    <= dirc_byte_next;
    end
  end

  // Next state: a split entry walks IDLE -> WR_LO -> WR_HI -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && is_split(head, PC_ADDR, SP_ADDR)) begin
          state_next = WR_LO;
        end
      end
      WR_LO:   state_next = WR_HI;
      WR_HI:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle; the low half of a split write is
  // launched from IDLE so that it is on the port while the FSM sits in WR_LO.
  always_comb begin
    pop               = 1'b0;
    load_held         = 1'b0;
    write_enable_next = 1'b1;
    write_addr_next   = write_addr;
    write_data_next   = write_data;
    dirc_byte_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop               = 1'b1;
          load_held         = is_split(head, PC_ADDR, SP_ADDR);
          write_enable_next = 1'b0;
          write_addr_next   = head.addr;
          write_data_next   = DW'(head.data[15:0]);
          dirc_byte_next    = 1'b0;
        end
      end
      WR_LO: begin
        write_enable_next = 1'b0;
        write_addr_next   = held_addr_reg;
        write_data_next   = DW'(held_hi_reg);
        dirc_byte_next    = 1'b1;
      end
      default: begin
        write_enable_next = 1'b1;
      end
    endcase
  end

  // Pending-write hit: any live FIFO entry, the held split entry, or the
  // write currently on the port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign fifo_hit[gi] = entry_valid[gi] && (entry_addr[gi] == chk_addr);
  end

  assign chk_hit = (|fifo_hit)
                || ((state_reg != IDLE) && (held_addr_reg == chk_addr))
                || (!write_enable && (write_addr == chk_addr));

  assign idle = (fifo_count == '0) && (state_reg == IDLE) && write_enable;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Scoreboard bench for reg_write_ctrl: expected register-file writes are
// queued as requests are accepted and matched against the write port.
module tb_reg_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_wide = 1'b0;
  logic        wb_ready;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        dirc_byte;
  logic [3:0]  chk_addr = '0;
  logic        chk_hit;
  logic        idle;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        half;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic saw_stall = 1'b0;

  reg_write_ctrl #(
    .DEPTH   (4),
    .DW      (16),
    .PC_ADDR (4'd8),
    .SP_ADDR (4'd9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_wide      (wb_wide),
    .wb_ready     (wb_ready),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .dirc_byte    (dirc_byte),
    .chk_addr     (chk_addr),
    .chk_hit      (chk_hit),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every active write cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && !write_enable) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(write_addr), 32'(mon_e.addr));
        check("wr_data", 32'(write_data), 32'(mon_e.data));
        check("wr_half", 32'(dirc_byte), 32'(mon_e.half));
      end
      $display("write addr=%0d data=0x%04h half=%0d", write_addr, write_data, dirc_byte);
    end
  end

  // Offer one request, wait (bounded) for acceptance, record expected writes.
  task automatic push(input logic [3:0] a, input logic [31:0] d, input logic w);
    int t = 0;
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    wb_wide  = w;
    while (!wb_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t > 0) saw_stall = 1'b1;
    if (t >= 50) check("push_timeout", 32'(t), 32'd0);
    if (w && (a == 4'd8 || a == 4'd9)) begin
      sb.push_back(exp_t'{addr: a, data: d[15:0], half: 1'b0});
      sb.push_back(exp_t'{addr: a, data: d[31:16], half: 1'b1});
    end else begin
      sb.push_back(exp_t'{addr: a, data: d[15:0], half: 1'b0});
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    $display("push addr=%0d data=0x%08h wide=%0d", a, d, w);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(write_enable), 32'd1);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_dirc", 32'(dirc_byte), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_hit", 32'(chk_hit), 32'd0);
    check("rst_ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single narrow write: two-edge latency, one write cycle
    push(4'd3, 32'h0000_ABCD, 1'b0);
    check("t1_lat_we", 32'(write_enable), 32'd1);
    @(posedge clk); #1;
    check("t1_we", 32'(write_enable), 32'd0);
    check("t1_addr", 32'(write_addr), 32'd3);
    check("t1_data", 32'(write_data), 32'h0000_ABCD);
    check("t1_dirc", 32'(dirc_byte), 32'd0);
    @(posedge clk); #1;
    check("t1_one_cycle", 32'(write_enable), 32'd1);
    check("t1_idle", 32'(idle), 32'd1);

    // Wide write to SP: low half, high half, one bubble
    push(4'd9, 32'h1234_5678, 1'b1);
    check("t2_lat_we", 32'(write_enable), 32'd1);
    @(posedge clk); #1;
    check("t2_lo_we", 32'(write_enable), 32'd0);
    check("t2_lo_data", 32'(write_data), 32'h5678);
    check("t2_lo_dirc", 32'(dirc_byte), 32'd0);
    @(posedge clk); #1;
    check("t2_hi_we", 32'(write_enable), 32'd0);
    check("t2_hi_addr", 32'(write_addr), 32'd9);
    check("t2_hi_data", 32'(write_data), 32'h1234);
    check("t2_hi_dirc", 32'(dirc_byte), 32'd1);
    @(posedge clk); #1;
    check("t2_bubble", 32'(write_enable), 32'd1);

    // Fill the FIFO behind two split writes; 5th narrow must stall
    saw_stall = 1'b0;
    push(4'd8, 32'h0808_0101, 1'b1);
    push(4'd9, 32'h0909_0202, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(4'(i), 32'h0000_1000 + 32'(i), 1'b0);
    end
    check("t3_ready_dropped", 32'(saw_stall), 32'd1);
    wait_drain("t3_drain");

    // Wide flag to a narrow register: single low-half write only
    push(4'd2, 32'hFFFF_0011, 1'b1);
    @(posedge clk); #1;
    check("t4_we", 32'(write_enable), 32'd0);
    check("t4_data", 32'(write_data), 32'h0011);
    check("t4_dirc", 32'(dirc_byte), 32'd0);
    @(posedge clk); #1;
    check("t4_no_second", 32'(write_enable), 32'd1);
    wait_drain("t4_drain");

    // Hazard hit against queued, held and completed writes
    push(4'd8, 32'hAAAA_BBBB, 1'b1);
    push(4'd5, 32'h0000_0055, 1'b0);
    chk_addr = 4'd5; #1;
    check("t5_hit_queued", 32'(chk_hit), 32'd1);
    chk_addr = 4'd6; #1;
    check("t5_miss", 32'(chk_hit), 32'd0);
    chk_addr = 4'd8; #1;
    check("t5_hit_held", 32'(chk_hit), 32'd1);
    chk_addr = 4'd5;
    wait_drain("t5_drain");
    check("t5_hit_done", 32'(chk_hit), 32'd0);

    // Reset in the middle of a split write
    push(4'd8, 32'hCAFE_F00D, 1'b1);
    @(posedge clk); #2;
    check("t6_in_wr_lo", 32'(write_enable), 32'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_we", 32'(write_enable), 32'd1);
    check("t6_rst_addr", 32'(write_addr), 32'd0);
    check("t6_rst_data", 32'(write_data), 32'd0);
    check("t6_rst_dirc", 32'(dirc_byte), 32'd0);
    check("t6_rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_wr_hi", 32'(write_enable), 32'd1);
    check("t6_idle", 32'(idle), 32'd1);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      push(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_drain("rand_drain");
    check("rand_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
